hyperram_wb_frontend: RTL
=========================

# hyperram_wb_frontend

Wishbone-classic slave front end sitting between the Caravel user-project Wishbone bus and the HyperBus controller core in the `hyperram` macro. Converts single Wishbone accesses into one-deep command/response transactions. Provides a small CSR window for the core's latency configuration and timeout status. Runs a watchdog that terminates hung accesses, asserting `hb_read_timeout` and completing the bus cycle.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000: window base; decode matches on `wbs_adr_i[31:24]`.
- `TIMEOUT_CYCLES`, 255: cycles allowed from entering ISSUE to response; minimum 2.
- `TIMEOUT_RDATA`, 32'hFFFF_FFFF: read data returned on timeout.

Ports (one clock, `wb_clk_i`; reset `wb_rst_i` is synchronous, active-high):
- `wb_clk_i`  in  1  system clock
- `wb_rst_i`  in  1  synchronous active-high reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone strobe, cycle, write enable
- `wbs_sel_i`  in  4  byte selects
- `wbs_adr_i`  in  32  byte address
- `wbs_dat_i`  in  32  write data
- `wbs_ack_o`  out  1  acknowledge
- `wbs_dat_o`  out  32  read data
- `cmd_valid_o`  out  1  command valid
- `cmd_ready_i`  in  1  core accepts command
- `cmd_we_o`  out  1  command is a write
- `cmd_addr_o`  out  22  word address, `wbs_adr_i[23:2]`
- `cmd_wdata_o`  out  32  write data
- `cmd_sel_o`  out  4  byte mask
- `cmd_abort_o`  out  1  one-cycle pulse; core releases CS#
- `rsp_valid_i`  in  1  core completion pulse, reads and writes
- `rsp_rdata_i`  in  32  read data, valid with `rsp_valid_i`
- `cfg_latency_o`  out  4  initial latency count to core
- `cfg_fixed_o`  out  1  fixed-latency mode to core
- `hb_read_timeout`  out  1  one-cycle pulse on watchdog expiry

## Operation
- **Decode:** hit = `stb & cyc & (adr[31:24] == BASE_ADDR[31:24])`. `adr[23]=1` selects CSR space; `adr[23]=0` selects memory. Non-hits are ignored entirely, with no ack.
- **FSM states:** IDLE, ISSUE, WAIT, ACK.
- **IDLE:**
  - Memory hit → ISSUE, latching we/addr/wdata/sel into the command registers.
  - CSR hit → ACK; the CSR write is applied, or the read data is latched, in the same cycle.
- **ISSUE:** `cmd_valid_o=1`. On `cmd_valid_o & cmd_ready_i` → WAIT. Command fields are held stable until accepted.
- **WAIT:** on `rsp_valid_i` → ACK, latching `rsp_rdata_i` for reads; `wbs_dat_o` is 0 for writes.
- **ACK:** `wbs_ack_o=1` for exactly one cycle, then → IDLE.
- **Watchdog:**
  - Counter cleared on IDLE→ISSUE; it increments in ISSUE and WAIT.
  - On reaching `TIMEOUT_CYCLES` without a response, the FSM goes → ACK with `wbs_dat_o=TIMEOUT_RDATA`.
  - In that expiry cycle `hb_read_timeout` and `cmd_abort_o` pulse, and `cmd_valid_o` drops.
  - The pulse fires for reads and writes alike.
- **CSRs** (offset = `adr[3:2]`, with `adr[23]=1`):
  - 0 CFG, RW: [3:0] latency (reset 6), [4] fixed (reset 1); drives `cfg_*_o`. Byte selects honoured.
  - 1 STATUS: [15:0] timeout count, RO, saturating at 16'hFFFF; [16] sticky timeout flag, W1C. Writing 1 to [16] also clears the count.
  - 2–3: read 0, writes ignored.
- **Boundary cases:**
  - `rsp_valid_i` in the same cycle as watchdog expiry: the response wins; no timeout pulse, no count.
  - `rsp_valid_i` outside WAIT: ignored.
  - A second strobe cannot be seen before IDLE, since the master drops `stb` after ack.
  - Expiry while a CSR W1C clear is written: the clear applies to prior state, then the count is set to 1 and the flag to 1.
  - Reset mid-transaction: FSM → IDLE and all outputs to reset values; no abort pulse; the core is reset by the same `wb_rst_i`.

## Timing
- **Reset values:** `wbs_ack_o=0`, `wbs_dat_o=0`, `cmd_valid_o=0`, `cmd_*` fields 0, `cmd_abort_o=0`, `hb_read_timeout=0`, `cfg_latency_o=6`, `cfg_fixed_o=1`, STATUS=0.
- **Memory access, best case:** stb sampled at cycle 0 → `cmd_valid_o` at 1 (ready=1) → WAIT at 2 (rsp at 2) → ack at 3.
- **CSR access:** ack at cycle 1.
- **Timeout:** expiry pulse on the cycle the counter equals `TIMEOUT_CYCLES`; ack follows one cycle later.
- All outputs are registered.

## Structure
- `hyperram_pkg` holds:
  - FSM state encoding;
  - CSR offsets (`CSR_CFG`, `CSR_STATUS`);
  - reset constants (`CFG_LATENCY_RST=6`, `CFG_FIXED_RST=1`);
  - STATUS bit positions.
- Sub-module `hyperram_wb_csr`: CFG/STATUS registers, W1C logic and saturating counter. Its inputs are a write strobe and a timeout pulse.
- The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide and lives in the top-level FSM.

## Test plan
- **Read, ready=1, rsp after 5 WAIT cycles with 32'hA5A5_1234:** ack exactly once; `wbs_dat_o`=32'hA5A5_1234; `cmd_addr_o`=`adr[23:2]`.
- **Write to 0x3000_0010, sel=4'b0011, cmd_ready delayed 3 cycles:** `cmd_valid_o` held with stable fields; `cmd_sel_o`=4'b0011, `cmd_addr_o`=4; ack one cycle after rsp.
- **Read with no rsp, TIMEOUT_CYCLES=16:** `hb_read_timeout` and `cmd_abort_o` single pulses at cycle 16; ack at 17 with 32'hFFFF_FFFF; STATUS reads 32'h0001_0001.
- **rsp_valid_i coincident with expiry:** normal data acked; no pulse; STATUS unchanged.
- **CSR traffic:**
  - write CFG=32'h0000_0003 with sel=4'b0001 → `cfg_latency_o`=3, `cfg_fixed_o`=0;
  - write 1<<16 to STATUS → reads 0;
  - access to 0x3080_000C reads 0;
  - access to 0x3100_0000 → no ack.
- **Reset asserted in WAIT:** next cycle all outputs at reset values; FSM idle; a subsequent read completes normally.

Source files
------------

// File: rtl/hyperram_pkg.sv
// Shared types and constants for the HyperRAM Wishbone front end.
// FSM encoding, CSR map and reset values.
package hyperram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [1:0]  CSR_CFG         = 2'd0;
  localparam logic [1:0]  CSR_STATUS      = 2'd1;

  localparam logic [3:0]  CFG_LATENCY_RST = 4'd6;
  localparam logic        CFG_FIXED_RST   = 1'b1;
  localparam int          CFG_FIXED_BIT   = 4;

  localparam int          STS_FLAG_BIT    = 16;
  localparam logic [15:0] STS_CNT_MAX     = 16'hFFFF;

endpackage

// File: rtl/hyperram_wb_frontend_if.sv
// Wishbone classic slave bus as seen by the HyperRAM front end.
// Signal names keep the Caravel wbs_* naming.
interface hyperram_wb_frontend_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/hyperram_wb_csr.sv
// CFG and STATUS registers: latency config, timeout counter and
// sticky W1C timeout flag.
module hyperram_wb_csr
  import hyperram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  offset,
  input  logic        sel0,
  input  logic [4:0]  cfg_wdata,
  input  logic        clr,
  input  logic        timeout,
  output logic [31:0] rdata,
  output logic [3:0]  cfg_latency,
  output logic        cfg_fixed
);

  logic [15:0] cnt;
  logic        flag;
  logic        cfg_hit;
  logic        clr_hit;

  assign cfg_hit = wr_en & (offset == CSR_CFG) & sel0;
  assign clr_hit = wr_en & (offset == CSR_STATUS) & clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_latency <= CFG_LATENCY_RST;
      cfg_fixed   <= CFG_FIXED_RST;
      cnt         <= '0;
      flag        <= 1'b0;
    end else begin
      if (cfg_hit) begin
        cfg_latency <= cfg_wdata[3:0];
        cfg_fixed   <= cfg_wdata[CFG_FIXED_BIT];
      end
      // A clear landing with a timeout wipes history, then counts this one.
      if (timeout) begin
        flag <= 1'b1;
        if (clr_hit)
          cnt <= 16'd1;
        else if (cnt != STS_CNT_MAX)
          cnt <= cnt + 16'd1;
      end else if (clr_hit) begin
        cnt  <= '0;
        flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      offset == CSR_CFG:
        rdata[CFG_FIXED_BIT:0] = {cfg_fixed, cfg_latency};
      offset == CSR_STATUS:
        rdata[STS_FLAG_BIT:0] = {flag, cnt};
      default: ;
    endcase
  end

endmodule

// File: rtl/hyperram_wb_frontend.sv
// Wishbone classic slave to one-deep HyperBus command/response bridge,
// with CSR window and a watchdog that terminates hung accesses.
module hyperram_wb_frontend
  import hyperram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  hyperram_wb_frontend_if.slave wb,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        cmd_we_o,
  output logic [21:0] cmd_addr_o,
  output logic [31:0] cmd_wdata_o,
  output logic [3:0]  cmd_sel_o,
  output logic        cmd_abort_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [3:0]  cfg_latency_o,
  output logic        cfg_fixed_o,
  output logic        hb_read_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            hit;
  logic            csr_we;
  logic            rsp_hit;
  logic            expire;
  logic [31:0]     csr_rdata;
  logic            unused_adr;

  assign hit = wb.wbs_stb_i & wb.wbs_cyc_i
             & (wb.wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign csr_we = (state == ST_IDLE) & hit
                & wb.wbs_adr_i[23] & wb.wbs_we_i;
  assign rsp_hit = (state == ST_WAIT) & rsp_valid_i;
  // Expiry is decided on the edge the counter reaches the limit;
  // a response on that same edge still wins.
  assign expire = (wd == WD_LAST) & ~rsp_hit;
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  hyperram_wb_csr u_csr (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .wr_en       (csr_we),
    .offset      (wb.wbs_adr_i[3:2]),
    .sel0        (wb.wbs_sel_i[0]),
    .cfg_wdata   (wb.wbs_dat_i[4:0]),
    .clr         (wb.wbs_dat_i[STS_FLAG_BIT]),
    .timeout     (hb_read_timeout),
    .rdata       (csr_rdata),
    .cfg_latency (cfg_latency_o),
    .cfg_fixed   (cfg_fixed_o)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= ST_IDLE;
      wd              <= '0;
      wb.wbs_ack_o    <= 1'b0;
      wb.wbs_dat_o    <= '0;
      cmd_valid_o     <= 1'b0;
      cmd_we_o        <= 1'b0;
      cmd_addr_o      <= '0;
      cmd_wdata_o     <= '0;
      cmd_sel_o       <= '0;
      cmd_abort_o     <= 1'b0;
      hb_read_timeout <= 1'b0;
    end else begin
      wb.wbs_ack_o    <= 1'b0;
      cmd_abort_o     <= 1'b0;
      hb_read_timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hit && wb.wbs_adr_i[23]) begin
            state        <= ST_ACK;
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= wb.wbs_we_i ? '0 : csr_rdata;
          end else if (hit) begin
            state       <= ST_ISSUE;
            wd          <= '0;
            cmd_valid_o <= 1'b1;
            cmd_we_o    <= wb.wbs_we_i;
            cmd_addr_o  <= wb.wbs_adr_i[23:2];
            cmd_wdata_o <= wb.wbs_dat_i;
            cmd_sel_o   <= wb.wbs_sel_i;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (hb_read_timeout) begin
            state        <= ST_ACK;
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= TIMEOUT_RDATA;
          end else if (expire) begin
            wd              <= wd + WD_W'(1);
            cmd_valid_o     <= 1'b0;
            cmd_abort_o     <= 1'b1;
            hb_read_timeout <= 1'b1;
          end else if (rsp_hit) begin
            state        <= ST_ACK;
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= cmd_we_o ? '0 : rsp_rdata_i;
          end else begin
            wd <= wd + WD_W'(1);
            if (state == ST_ISSUE && cmd_valid_o && cmd_ready_i) begin
              cmd_valid_o <= 1'b0;
              state       <= ST_WAIT;
            end
          end
        end
        ST_ACK: state <= ST_IDLE;
      endcase
    end
  end

endmodule
